mult_rr_scheduler: RTL and testbench
====================================

// Module: mult_rr_scheduler
// PURPOSE
//  Round-robin scheduler that shares one Carry_Save_Multiplier instance among NREQ
//  requesters, e.g. PE lanes of the accelerator.
//  Arbitrates valid/ready requests and latches the winner's operands.
//  Sequences the multiply and holds a tagged, registered result until the consumer accepts it.
// PARAMETERS
//  WIDTH  8  operand width; passed to the multiplier
//  NREQ   4  number of requesters (>=2); ID_W = $clog2(NREQ)
// PORTS
//  clk        in   1              single clock, rising edge
//  rst_n      in   1              synchronous, active-low reset
//  req_valid  in   NREQ           per-requester request valid
//  req_ready  out  NREQ           one-hot grant / operand accept
//  req_a      in   NREQ*WIDTH     operand A, requester i at [i*WIDTH +: WIDTH]
//  req_b      in   NREQ*WIDTH     operand B, same packing
//  res_valid  out  1              result valid
//  res_ready  in   1              consumer accepts result
//  res_data   out  2*WIDTH+1      product A*B, unsigned, zero-extended
//  res_id     out  ID_W           index of requester that owns res_data
//  busy       out  1              state != IDLE
//  op_count   out  32             completed results (res_valid&res_ready), wraps at 2^32
// BEHAVIOUR
//  Clock and reset: one clock; reset is synchronous and active-low.
//  Reset values:
//   - state=IDLE; res_valid=0; res_data=0; res_id=0; op_count=0; busy=0; req_ready=0.
//   - rr_ptr=NREQ-1, so requester 0 has top priority after reset.
//  FSM states: IDLE -> CALC -> [CALC2] -> HOLD -> IDLE.
//  IDLE:
//   - Winner = first i with req_valid[i] set, searching rr_ptr+1, rr_ptr+2, ... mod NREQ.
//   - req_ready[winner]=1 combinationally; all other bits are 0.
//   - No valid request: stay in IDLE.
//  Handshake edge (req_valid[w] & req_ready[w]):
//   - Latch a_q, b_q and id_q=w; set rr_ptr=w; go to CALC.
//  req_ready: all-zero in every state except IDLE. There is no overlap of accept and result.
//  CALC:
//   - The multiplier sees a_q/b_q.
//   - At the edge: res_data <= product, res_id <= id_q, res_valid <= 1; go to HOLD.
//  HOLD:
//   - res_valid, res_data and res_id stay stable while res_ready=0.
//   - On res_valid&res_ready: res_valid<=0, op_count+=1, go to IDLE.
//  Latency:
//   - Handshake at edge T gives res_valid high from edge T+1.
//   - A requester may be granted again at the earliest 1 cycle after the result is accepted.
//   - Peak throughput: 1 result per 3 cycles with zero backpressure.
//  Fairness:
//   - With all requesters continuously valid, grants rotate 0,1,...,NREQ-1,0.
//   - A requester dropping valid is skipped; no starvation.
//  req_valid changing in a non-IDLE state: ignored, no effect on state or rr_ptr.
//  Arithmetic:
//   - res_data equals A*B exactly; bit 2*WIDTH is always 0 for unsigned operands.
//   - op_count wraps from 0xFFFFFFFF to 0.
//  Reset mid-operation (any state):
//   - Return to IDLE next edge; the in-flight result is discarded.
//   - rr_ptr and op_count return to reset values.
// CONFIGURATION
//  Macro MULT_PIPE_EN:
//   - Defined: adds state CALC2. CALC registers the product into an internal stage;
//     CALC2 moves it to res_data/res_valid. Latency becomes handshake edge T to res_valid at T+2.
//     Throughput becomes 1 per 4 cycles.
//   - Undefined: no CALC2; latency 1 as above.
// TESTING (WIDTH=8, NREQ=4; run every case with and without MULT_PIPE_EN)
//  1. Reset: hold rst_n=0 for 3 cycles with random inputs ->
//     res_valid=0, req_ready=0, busy=0, op_count=0, res_data=0.
//  2. Single request: req_valid=4'b0001, a=13, b=11, res_ready=1 ->
//     res_data=143, res_id=0, res_valid 1 cycle after handshake (2 with MULT_PIPE_EN); op_count=1.
//  3. Fairness: req_valid=4'b1111 held, res_ready=1 ->
//     grant order 0,1,2,3,0; req_ready is one-hot or zero every cycle.
//  4. Corner operands:
//     - 255*255 -> 65025 with bit16=0.
//     - 0*200 -> 0.
//     - 1*255 -> 255.
//  5. Backpressure: res_ready=0 for 5 cycles in HOLD, with req_valid=4'b0110 ->
//     res_data/res_id stable, req_ready=0; after res_ready=1, next grant is the requester after rr_ptr.
//  6. Reset mid-op: drop rst_n in CALC ->
//     IDLE next cycle, res_valid=0, no result emitted; after release, req 0 is granted first.

Source files
------------

// File: rtl/mult_rr_scheduler.sv
// Round-robin scheduler sharing one carry-save multiplier among NREQ requesters.
// Optional macro MULT_PIPE_EN adds a CALC2 stage that registers the product before the result.

module Carry_Save_Multiplier #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product
);

    logic [2*WIDTH-1:0] sum;
    logic [2*WIDTH-1:0] carry;
    logic [2*WIDTH-1:0] pp;
    logic [2*WIDTH-1:0] nxt_carry;

    // Partial products are folded into a sum/carry pair; one ripple add resolves them at the end.
    always_comb begin
        sum       = '0;
        carry     = '0;
        pp        = '0;
        nxt_carry = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pp        = b[i] ? ({{WIDTH{1'b0}}, a} << i) : '0;
            nxt_carry = ((sum & carry) | (sum & pp) | (carry & pp)) << 1;
            sum       = sum ^ carry ^ pp;
            carry     = nxt_carry;
        end
        product = sum + carry;
    end

endmodule

module mult_rr_scheduler #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    localparam int ID_W = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [2*WIDTH:0]      res_data,
    output logic [ID_W-1:0]       res_id,
    output logic                  busy,
    output logic [31:0]           op_count
);

`ifdef MULT_PIPE_EN
    typedef enum logic [1:0] {IDLE, CALC, CALC2, HOLD} state_t;
`else
    typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;
`endif

    state_t             state;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    cand;
    logic [ID_W-1:0]    winner;
    logic               grant_ok;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [ID_W-1:0]    id_q;
    logic [2*WIDTH-1:0] product;
`ifdef MULT_PIPE_EN
    logic [2*WIDTH-1:0] prod_q;
`endif

    // Scanning from the farthest candidate back to rr_ptr+1 leaves the closest valid one as winner.
    always_comb begin
        grant_ok = 1'b0;
        winner   = '0;
        cand     = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = ID_W'((int'(rr_ptr) + k) % NREQ);
            if (req_valid[cand]) begin
                grant_ok = 1'b1;
                winner   = cand;
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner == ID_W'(i)) begin
                sel_a = req_a[i*WIDTH +: WIDTH];
                sel_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // Grants are suppressed while reset is asserted so nothing is accepted during reset.
    always_comb begin
        req_ready = '0;
        if (rst_n && state == IDLE && grant_ok) begin
            req_ready[winner] = 1'b1;
        end
    end

    assign busy = (state != IDLE);

    Carry_Save_Multiplier #(.WIDTH(WIDTH)) u_mult (
        .a       (a_q),
        .b       (b_q),
        .product (product)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= ID_W'(NREQ - 1);
            a_q       <= '0;
            b_q       <= '0;
            id_q      <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
            op_count  <= '0;
`ifdef MULT_PIPE_EN
            prod_q    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_ok) begin
                        a_q    <= sel_a;
                        b_q    <= sel_b;
                        id_q   <= winner;
                        rr_ptr <= winner;
                        state  <= CALC;
                    end
                end
`ifdef MULT_PIPE_EN
                CALC: begin
                    prod_q <= product;
                    state  <= CALC2;
                end
                CALC2: begin
                    res_data  <= {1'b0, prod_q};
                    res_id    <= id_q;
                    res_valid <= 1'b1;
                    state     <= HOLD;
                end
`else
                CALC: begin
                    res_data  <= {1'b0, product};
                    res_id    <= id_q;
                    res_valid <= 1'b1;
                    state     <= HOLD;
                end
`endif
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        op_count  <= op_count + 32'd1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Self-checking bench for mult_rr_scheduler: vector table, hand-written corner sequences
// and randomized traffic compared against a transaction-level reference model.

module tb_mult_rr_scheduler;

`ifdef MULT_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        res_valid;
    logic        res_ready;
    logic [16:0] res_data;
    logic [1:0]  res_id;
    logic        busy;
    logic [31:0] op_count;

    mult_rr_scheduler #(.WIDTH(8), .NREQ(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .busy      (busy),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        resReady;
        logic [3:0]  expReady;
        logic        expValid;
        logic [16:0] expData;
        logic [1:0]  expId;
        logic        expBusy;
        logic [31:0] expCount;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;
    bit   useModel = 1'b0;

    logic [3:0]  s_ready;
    logic        s_valid;
    logic [16:0] s_data;
    logic [1:0]  s_id;
    logic        s_busy;
    logic [31:0] s_count;

    // Transaction-level model: a countdown stands in for the multiply latency.
    bit          m_busy  = 1'b0;
    int          m_wait  = 0;
    bit          m_valid = 1'b0;
    logic [16:0] m_data  = '0;
    logic [1:0]  m_id    = '0;
    int          m_last  = 3;
    logic [31:0] m_count = '0;
    logic [16:0] m_pend  = '0;
    logic [1:0]  m_pendId = '0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [3:0] valid, input logic [31:0] a,
                                 input logic [31:0] b, input logic rr);
        rst_n     = rst;
        req_valid = valid;
        req_a     = a;
        req_b     = b;
        res_ready = rr;
    endtask

    function automatic int firstFrom(input logic [3:0] valid);
        for (int k = 1; k <= 4; k++) begin
            if (valid[(m_last + k) % 4]) return (m_last + k) % 4;
        end
        return -1;
    endfunction

    task automatic compareModel();
        logic [3:0] er;
        int w;
        er = '0;
        if (rst_n && !m_busy) begin
            w = firstFrom(req_valid);
            if (w >= 0) er[w] = 1'b1;
        end
        checkOutput("rndReady", 32'(s_ready), 32'(er));
        checkOutput("rndValid", 32'(s_valid), 32'(m_valid));
        checkOutput("rndData",  32'(s_data),  32'(m_data));
        checkOutput("rndId",    32'(s_id),    32'(m_id));
        checkOutput("rndBusy",  32'(s_busy),  32'(m_busy));
        checkOutput("rndCount", s_count, m_count);
    endtask

    task automatic modelUpdate();
        int w;
        int pa;
        int pb;
        if (!rst_n) begin
            m_busy = 1'b0; m_wait = 0; m_valid = 1'b0; m_data = '0; m_id = '0;
            m_last = 3; m_count = '0;
        end else if (!m_busy) begin
            w = firstFrom(req_valid);
            if (w >= 0) begin
                pa = int'(req_a[w*8 +: 8]);
                pb = int'(req_b[w*8 +: 8]);
                m_pend   = 17'(pa * pb);
                m_pendId = 2'(w);
                m_last   = w;
                m_busy   = 1'b1;
                m_wait   = LAT;
            end
        end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) begin
                m_valid = 1'b1;
                m_data  = m_pend;
                m_id    = m_pendId;
            end
        end else if (res_ready) begin
            m_valid = 1'b0;
            m_count = m_count + 32'd1;
            m_busy  = 1'b0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        s_ready = req_ready;
        s_valid = res_valid;
        s_data  = res_data;
        s_id    = res_id;
        s_busy  = busy;
        s_count = op_count;
        if (useModel) compareModel();
        modelUpdate();
        @(posedge clk);
        #1;
    endtask

    task automatic addTxn(input int lane, input logic [7:0] a, input logic [7:0] b,
                          input logic [16:0] prod, input logic [31:0] cnt);
        vec_t v;
        v = '{4'(1 << lane), a, b, 1'b1, 4'(1 << lane), 1'b0, 17'd0, 2'd0, 1'b0, cnt};
        vecs.push_back(v);
        for (int j = 0; j < LAT; j++) begin
            v = '{4'b0, 8'd0, 8'd0, 1'b1, 4'b0, 1'b0, 17'd0, 2'd0, 1'b1, cnt};
            vecs.push_back(v);
        end
        v = '{4'b0, 8'd0, 8'd0, 1'b1, 4'b0, 1'b1, prod, 2'(lane), 1'b1, cnt};
        vecs.push_back(v);
    endtask

    task automatic drain();
        applyStimulus(1'b1, 4'b0, $urandom, $urandom, 1'b1);
        for (int i = 0; i < LAT + 3; i++) tick();
    endtask

    initial begin
        int grants[$];
        logic [31:0] va;
        logic [31:0] vb;
        vec_t v;

        applyStimulus(1'b0, 4'($urandom), $urandom, $urandom, 1'($urandom));
        @(posedge clk);
        #1;

        // Reset held with random inputs.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 4'($urandom), $urandom, $urandom, 1'($urandom));
            tick();
        end
        applyStimulus(1'b0, 4'b1111, $urandom, $urandom, 1'b1);
        tick();
        checkOutput("rstValid", 32'(s_valid), 32'd0);
        checkOutput("rstReady", 32'(s_ready), 32'd0);
        checkOutput("rstBusy",  32'(s_busy),  32'd0);
        checkOutput("rstCount", s_count,      32'd0);
        checkOutput("rstData",  32'(s_data),  32'd0);

        // Vector table: single request and corner operands on each lane.
        v = '{4'b0, 8'd0, 8'd0, 1'b1, 4'b0, 1'b0, 17'd0, 2'd0, 1'b0, 32'd0};
        vecs.push_back(v);
        addTxn(0, 8'd13,  8'd11,  17'd143,   32'd0);
        addTxn(1, 8'd255, 8'd255, 17'd65025, 32'd1);
        addTxn(2, 8'd0,   8'd200, 17'd0,     32'd2);
        addTxn(3, 8'd1,   8'd255, 17'd255,   32'd3);
        v = '{4'b0, 8'd0, 8'd0, 1'b1, 4'b0, 1'b0, 17'd0, 2'd0, 1'b0, 32'd4};
        vecs.push_back(v);
        foreach (vecs[n]) begin
            va = $urandom;
            vb = $urandom;
            for (int l = 0; l < 4; l++) begin
                if (vecs[n].valid[l]) begin
                    va[l*8 +: 8] = vecs[n].a;
                    vb[l*8 +: 8] = vecs[n].b;
                end
            end
            applyStimulus(1'b1, vecs[n].valid, va, vb, vecs[n].resReady);
            tick();
            checkOutput($sformatf("vecReady%0d", n), 32'(s_ready), 32'(vecs[n].expReady));
            checkOutput($sformatf("vecValid%0d", n), 32'(s_valid), 32'(vecs[n].expValid));
            checkOutput($sformatf("vecBusy%0d", n),  32'(s_busy),  32'(vecs[n].expBusy));
            checkOutput($sformatf("vecCount%0d", n), s_count,      vecs[n].expCount);
            if (vecs[n].expValid) begin
                checkOutput($sformatf("vecData%0d", n), 32'(s_data), 32'(vecs[n].expData));
                checkOutput($sformatf("vecId%0d", n),   32'(s_id),   32'(vecs[n].expId));
            end
        end

        // Fairness: all requesters valid after reset rotate 0,1,2,3,0.
        applyStimulus(1'b0, 4'b0, $urandom, $urandom, 1'b1);
        tick();
        tick();
        applyStimulus(1'b1, 4'b1111, $urandom, $urandom, 1'b1);
        for (int c = 0; c < 40 && grants.size() < 5; c++) begin
            tick();
            checkOutput("fairOneHot", 32'($onehot0(s_ready)), 32'd1);
            for (int l = 0; l < 4; l++) if (s_ready[l]) grants.push_back(l);
        end
        checkOutput("fairGrantCount", 32'(grants.size()), 32'd5);
        foreach (grants[i]) checkOutput($sformatf("fairGrant%0d", i), 32'(grants[i]), 32'(i % 4));
        drain();

        // Backpressure: result held stable, then the next lane after the last winner is granted.
        applyStimulus(1'b0, 4'b0, $urandom, $urandom, 1'b1);
        tick();
        applyStimulus(1'b1, 4'b0110, 32'h0005_C800, 32'h0006_0300, 1'b0);
        tick();
        checkOutput("bpGrant", 32'(s_ready), 32'b0010);
        for (int i = 0; i < LAT; i++) begin
            tick();
            checkOutput("bpCalcReady", 32'(s_ready), 32'd0);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("bpHoldValid", 32'(s_valid), 32'd1);
            checkOutput("bpHoldData",  32'(s_data),  32'd600);
            checkOutput("bpHoldId",    32'(s_id),    32'd1);
            checkOutput("bpHoldReady", 32'(s_ready), 32'd0);
        end
        res_ready = 1'b1;
        tick();
        tick();
        checkOutput("bpNextGrant", 32'(s_ready), 32'b0100);
        drain();

        // Reset while CALC: result discarded, priority back to requester 0.
        applyStimulus(1'b1, 4'b1000, 32'h0700_0000, 32'h0900_0000, 1'b1);
        tick();
        checkOutput("midGrant", 32'(s_ready), 32'b1000);
        applyStimulus(1'b0, 4'b0, $urandom, $urandom, 1'b1);
        tick();
        checkOutput("midBusyInCalc", 32'(s_busy), 32'd1);
        applyStimulus(1'b1, 4'b0, $urandom, $urandom, 1'b1);
        tick();
        checkOutput("midBusy",  32'(s_busy), 32'd0);
        checkOutput("midCount", s_count,     32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("midNoResult", 32'(s_valid), 32'd0);
        end
        applyStimulus(1'b1, 4'b1111, $urandom, $urandom, 1'b1);
        tick();
        checkOutput("midFirstGrant", 32'(s_ready), 32'b0001);
        drain();

        // Randomized traffic against the reference model.
        useModel = 1'b1;
        for (int c = 0; c < 400; c++) begin
            applyStimulus(1'($urandom_range(0, 39) != 0), 4'($urandom), $urandom, $urandom,
                          1'($urandom_range(0, 9) < 7));
            tick();
        end
        useModel = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
